// File: rtl/sonar_pkg.sv
// Shared types and helpers for the sonar scheduler: FSM state encoding,
// the "no echo" marker and the channel-selection functions.
package sonar_pkg;

  localparam int MAX_CH = 8;
  localparam int W_DEF  = 20;
  localparam logic [W_DEF-1:0] NO_ECHO = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_HOLD,
    ST_MEAS,
    ST_STORE,
    ST_GAP
  } state_t;

  // Returns {found, index} of the lowest set bit in mask.
  function automatic logic [3:0] lowest_set(input logic [MAX_CH-1:0] mask);
    logic [3:0] r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Returns {found, index} of the lowest set bit strictly above cur.
  function automatic logic [3:0] next_set(input logic [MAX_CH-1:0] mask, input logic [2:0] cur);
    logic [3:0] r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) > cur)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/sonar_scheduler_if.sv
// Bundles the sensor pads, control inputs and result-bank read port of the
// sonar scheduler; the scheduler uses the slave modport.
interface sonar_scheduler_if #(
  parameter int N_CH = 4,
  parameter int W    = 20
);
  localparam int CW = $clog2(N_CH);

  logic            en;
  logic [N_CH-1:0] ch_mask;
  logic [N_CH-1:0] sig_in;
  logic [N_CH-1:0] sig_out;
  logic [N_CH-1:0] sig_oe;
  logic [CW-1:0]   rd_ch;
  logic [W-1:0]    rd_time;
  logic [N_CH-1:0] rd_valid;
  logic            sweep_done;
  logic            busy;

  modport master (
    output en, ch_mask, sig_in, rd_ch,
    input  sig_out, sig_oe, rd_time, rd_valid, sweep_done, busy
  );

  modport slave (
    input  en, ch_mask, sig_in, rd_ch,
    output sig_out, sig_oe, rd_time, rd_valid, sweep_done, busy
  );
endinterface

// File: rtl/sonar_echo_counter.sv
// Echo-width counter: 2-FF synchroniser on every pad, saturating count of the
// selected channel. Define SONAR_FIRST_PULSE_EN to count only the first high run.
module sonar_echo_counter #(
  parameter int N_CH = 4,
  parameter int W    = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         sig_in,
  input  logic [$clog2(N_CH)-1:0] sel,
  input  logic                    clear,
  input  logic                    enable,
  output logic [W-1:0]            count
);
  // Saturate one below all-ones so a long echo never reads as "no echo".
  localparam logic [W-1:0] SAT = ~W'(1);

  logic [N_CH-1:0] sync1_reg, sync2_reg;
  logic [W-1:0]    count_reg;
  logic            echo;

  assign echo  = sync2_reg[sel];
  assign count = count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sig_in;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef SONAR_FIRST_PULSE_EN
  logic seen_reg, done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      seen_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (clear) begin
      count_reg <= '0;
      seen_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (enable) begin
      if (echo) begin
        seen_reg <= 1'b1;
        if (!done_reg && count_reg != SAT) count_reg <= count_reg + W'(1);
      end else if (seen_reg) begin
        done_reg <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && echo && count_reg != SAT) begin
      count_reg <= count_reg + W'(1);
    end
  end
`endif

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic sensor scheduler: trigger, hold-off, echo measurement
// and result bank per enabled channel. Optional macro: SONAR_FIRST_PULSE_EN.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = 20,
  parameter int TRIG_CYC = 250,
  parameter int HOLD_CYC = 35000,
  parameter int WIN_CYC  = 930000,
  parameter int GAP_CYC  = 50
) (
  input logic               clk,
  input logic               rst,
  sonar_scheduler_if.slave  bus
);
  localparam int CW = $clog2(N_CH);

  state_t          state_reg, state_next;
  logic [31:0]     phase_reg, phase_next;
  logic [CW-1:0]   cur_reg, cur_next;
  logic [N_CH-1:0] oe_reg, oe_next, out_reg, out_next, valid_reg;
  logic            sweep_reg, sweep_next;
  logic [W-1:0]    bank [N_CH];
  logic [W-1:0]    rd_time_reg, count;
  logic [3:0]      low_sel, up_sel;
  logic [MAX_CH-1:0] mask8;
  logic            clear, meas;

  assign mask8   = MAX_CH'(bus.ch_mask);
  assign low_sel = lowest_set(mask8);
  assign up_sel  = next_set(mask8, 3'(cur_reg));
  assign meas    = (state_reg == ST_MEAS);
  assign clear   = (state_reg == ST_HOLD) && (state_next == ST_MEAS);

  sonar_echo_counter #(.N_CH(N_CH), .W(W)) u_counter (
    .clk    (clk),
    .rst    (rst),
    .sig_in (bus.sig_in),
    .sel    (cur_reg),
    .clear  (clear),
    .enable (meas),
    .count  (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      phase_reg <= '0;
      cur_reg   <= '0;
      oe_reg    <= '0;
      out_reg   <= '0;
      sweep_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      cur_reg   <= cur_next;
      oe_reg    <= oe_next;
      out_reg   <= out_next;
      sweep_reg <= sweep_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg + 32'd1;
    cur_next   = cur_reg;
    sweep_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        phase_next = '0;
        if (bus.en && low_sel[3]) begin
          state_next = ST_TRIG;
          cur_next   = CW'(low_sel[2:0]);
        end
      end
      ST_TRIG: if (phase_reg == 32'(TRIG_CYC - 1)) begin
        state_next = ST_HOLD;
        phase_next = '0;
      end
      ST_HOLD: if (phase_reg == 32'(HOLD_CYC - 1)) begin
        state_next = ST_MEAS;
        phase_next = '0;
      end
      ST_MEAS: if (phase_reg == 32'(WIN_CYC - 1)) begin
        state_next = ST_STORE;
        phase_next = '0;
      end
      ST_STORE: begin
        state_next = ST_GAP;
        phase_next = '0;
      end
      ST_GAP: if (phase_reg == 32'(GAP_CYC - 1)) begin
        // Mask is sampled only here, so edits mid-channel apply to the next pick.
        phase_next = '0;
        sweep_next = !up_sel[3];
        state_next = ST_IDLE;
        if (bus.en) begin
          if (up_sel[3]) begin
            state_next = ST_TRIG;
            cur_next   = CW'(up_sel[2:0]);
          end else if (low_sel[3]) begin
            state_next = ST_TRIG;
            cur_next   = CW'(low_sel[2:0]);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    oe_next  = '0;
    out_next = '0;
    if (state_next == ST_TRIG) begin
      oe_next[cur_next]  = 1'b1;
      out_next[cur_next] = 1'b1;
    end else if (state_next == ST_HOLD) begin
      oe_next[cur_next]  = 1'b1;
    end
  end

  // Read uses the pre-write array contents, so a same-cycle store shows next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) bank[i] <= '1;
      valid_reg   <= '0;
      rd_time_reg <= '0;
    end else begin
      if (state_reg == ST_STORE) begin
        bank[cur_reg]      <= (count == '0) ? '1 : count;
        valid_reg[cur_reg] <= 1'b1;
      end
      rd_time_reg <= bank[bus.rd_ch];
    end
  end

  assign bus.sig_oe     = oe_reg;
  assign bus.sig_out    = out_reg;
  assign bus.rd_time    = rd_time_reg;
  assign bus.rd_valid   = valid_reg;
  assign bus.sweep_done = sweep_reg;
  assign bus.busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sonar_scheduler.sv
// Scoreboard bench for sonar_scheduler: a sensor model answers each measurement
// window with an echo pattern and queues the expected width; a monitor reads it back.
module tb_sonar_scheduler;
  import sonar_pkg::*;

  localparam int N = 4;

  logic clk;
  logic rst;

  sonar_scheduler_if #(.N_CH(N), .W(20)) bus ();

  sonar_scheduler #(
    .N_CH(N), .W(20), .TRIG_CYC(4), .HOLD_CYC(10), .WIN_CYC(100), .GAP_CYC(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [19:0] t;
    bit          valid;
    bit          imm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   use_plan;
  int   plan_d[N], plan_h1[N], plan_l[N], plan_h2[N];
  int   oe_cyc[N], out_cyc[N], trig_cnt[N];
  int   sweep_cnt = 0;
  int   busy_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Expected bank value from the echo shape alone.
  function automatic logic [19:0] model(input int h1, input int h2);
    int v;
`ifdef SONAR_FIRST_PULSE_EN
    v = (h1 != 0) ? h1 : h2;
`else
    v = h1 + h2;
`endif
    return (v == 0) ? NO_ECHO : 20'(v);
  endfunction

  // Sensor model: when a pad releases, answer inside the measurement window.
  initial begin
    logic [N-1:0] prev_oe;
    int c, d, h1, l, h2;
    exp_t e;
    bus.sig_in = '0;
    prev_oe = '0;
    forever begin
      @(negedge clk);
      c = -1;
      for (int i = 0; i < N; i++)
        if (prev_oe[i] && !bus.sig_oe[i] && !rst) c = i;
      prev_oe = bus.sig_oe;
      if (c >= 0) begin
        if (use_plan) begin
          d = plan_d[c]; h1 = plan_h1[c]; l = plan_l[c]; h2 = plan_h2[c];
        end else begin
          d = $urandom_range(2, 15); h1 = $urandom_range(0, 25);
          l = $urandom_range(1, 10); h2 = $urandom_range(0, 25);
        end
        e.ch = c; e.t = model(h1, h2); e.valid = 1'b1; e.imm = 1'b0;
        exp_q.push_back(e);
        repeat (d) @(negedge clk);
        bus.sig_in[c] = 1'b1;
        repeat (h1) @(negedge clk);
        bus.sig_in[c] = 1'b0;
        repeat (l) @(negedge clk);
        bus.sig_in[c] = 1'b1;
        repeat (h2) @(negedge clk);
        bus.sig_in[c] = 1'b0;
      end
    end
  end

  // Monitor: a result is due once the DUT moves on (next trigger or idle).
  initial begin
    logic [N-1:0] prev_oe;
    logic prev_busy, ev;
    exp_t e;
    bus.rd_ch = '0;
    prev_oe = '0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      ev = (prev_oe == '0 && bus.sig_oe != '0) || (prev_busy && !bus.busy);
      prev_oe = bus.sig_oe;
      prev_busy = bus.busy;
      if (!rst && exp_q.size() > 0 && (ev || exp_q[0].imm)) begin
        e = exp_q.pop_front();
        bus.rd_ch = 2'(e.ch);
        @(negedge clk);
        $display("txn ch=%0d rd_time=%h want=%h rd_valid=%b", e.ch, bus.rd_time, e.t, bus.rd_valid);
        check("rd_time", 32'(bus.rd_time), 32'(e.t));
        check("rd_valid_bit", 32'(bus.rd_valid[e.ch]), 32'(e.valid));
        prev_oe = bus.sig_oe;
        prev_busy = bus.busy;
      end
    end
  end

  // Activity counters and pad-drive invariants.
  initial begin
    logic [N-1:0] prev_oe;
    prev_oe = '0;
    for (int i = 0; i < N; i++) begin
      oe_cyc[i] = 0; out_cyc[i] = 0; trig_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.sig_oe[i]) oe_cyc[i]++;
        if (bus.sig_out[i]) out_cyc[i]++;
        if (bus.sig_oe[i] && !prev_oe[i]) trig_cnt[i]++;
      end
      prev_oe = bus.sig_oe;
      if (bus.sweep_done) sweep_cnt++;
      if (bus.busy) busy_cyc++;
      checks++;
      if (!$onehot0(bus.sig_oe) || (bus.sig_out & ~bus.sig_oe) != '0 || (!bus.busy && bus.sig_oe != '0)) begin
        errors++;
        $display("FAIL pad_drive: oe=%b out=%b busy=%b", bus.sig_oe, bus.sig_out, bus.busy);
      end
    end
  end

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_oe(input int c, input logic level, input int limit, input string name);
    int n = 0;
    while (bus.sig_oe[c] !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.sig_oe[c]), 32'(level));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_plan(input int c, input int d, input int h1, input int l, input int h2);
    plan_d[c] = d; plan_h1[c] = h1; plan_l[c] = l; plan_h2[c] = h2;
  endtask

  initial begin
    int base_a, base_b, n;
    exp_t e;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.ch_mask = '0;
    use_plan = 1'b1;
    for (int i = 0; i < N; i++) set_plan(i, 5, 0, 1, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_oe", 32'(bus.sig_oe), 32'd0);
    check("rst_out", 32'(bus.sig_out), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_sweep_done", 32'(bus.sweep_done), 32'd0);
    check("rst_rd_time", 32'(bus.rd_time), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("bank_init_ch0", 32'(bus.rd_time), 32'hFFFFF);

    // Empty mask: never leaves IDLE.
    bus.ch_mask = 4'b0000;
    bus.en = 1'b1;
    base_a = busy_cyc;
    base_b = oe_cyc[0] + oe_cyc[1] + oe_cyc[2] + oe_cyc[3];
    repeat (1000) @(negedge clk);
    check("mask0_busy_cycles", 32'(busy_cyc - base_a), 32'd0);
    check("mask0_oe_cycles", 32'(oe_cyc[0] + oe_cyc[1] + oe_cyc[2] + oe_cyc[3] - base_b), 32'd0);
    bus.en = 1'b0;

    // Two-channel sweeps with fixed echoes.
    set_plan(0, 10, 30, 1, 0);
    set_plan(2, 10, 55, 1, 0);
    bus.ch_mask = 4'b0101;
    base_a = sweep_cnt;
    base_b = trig_cnt[2];
    bus.en = 1'b1;
    n = 0;
    while (sweep_cnt - base_a < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    bus.en = 1'b0;
    wait_idle("t1_idle", 500);
    drain("t1_drain");
    check("t1_sweeps", 32'(sweep_cnt - base_a), 32'd3);
    check("t1_sweep_per_ch2", 32'(sweep_cnt - base_a), 32'(trig_cnt[2] - base_b));
    check("t1_rd_valid", 32'(bus.rd_valid), 32'b0101);

    // Single channel, no echo: pad timing.
    set_plan(1, 5, 0, 1, 0);
    bus.ch_mask = 4'b0010;
    base_a = oe_cyc[1];
    base_b = out_cyc[1];
    bus.en = 1'b1;
    @(negedge clk);
    wait_oe(1, 1'b1, 50, "t2_trig_start");
    bus.en = 1'b0;
    wait_idle("t2_idle", 500);
    drain("t2_drain");
    check("t2_oe_cycles", 32'(oe_cyc[1] - base_a), 32'd14);
    check("t2_out_cycles", 32'(out_cyc[1] - base_b), 32'd4);

    // Split echo on channel 0.
    set_plan(0, 5, 10, 5, 20);
    bus.ch_mask = 4'b0001;
    bus.en = 1'b1;
    @(negedge clk);
    wait_oe(0, 1'b1, 50, "t3_trig_start");
    bus.en = 1'b0;
    wait_idle("t3_idle", 500);
    drain("t3_drain");

    // EN dropped during channel 0 measurement.
    set_plan(0, 5, 20, 1, 0);
    bus.ch_mask = 4'b0011;
    base_a = trig_cnt[1];
    bus.en = 1'b1;
    @(negedge clk);
    wait_oe(0, 1'b1, 50, "t4_trig_start");
    wait_oe(0, 1'b0, 50, "t4_meas_start");
    bus.en = 1'b0;
    wait_idle("t4_idle", 500);
    repeat (30) @(negedge clk);
    check("t4_ch1_triggers", 32'(trig_cnt[1] - base_a), 32'd0);
    check("t4_busy_after", 32'(bus.busy), 32'd0);
    drain("t4_drain");

    // Randomised echoes over random masks.
    use_plan = 1'b0;
    for (int it = 0; it < 4; it++) begin
      bus.ch_mask = 4'($urandom_range(1, 15));
      base_a = sweep_cnt;
      bus.en = 1'b1;
      n = 0;
      while (sweep_cnt - base_a < 2 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("rand_sweeps_seen", 32'(sweep_cnt - base_a >= 2), 32'd1);
      bus.en = 1'b0;
      wait_idle("rand_idle", 600);
      drain("rand_drain");
    end
    use_plan = 1'b1;

    // Reset during HOLD of channel 0.
    set_plan(0, 5, 12, 1, 0);
    bus.ch_mask = 4'b0011;
    bus.en = 1'b1;
    n = 0;
    while (!(bus.sig_oe[0] && !bus.sig_out[0]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_hold", 32'(bus.sig_oe[0] && !bus.sig_out[0]), 32'd1);
    #2 rst = 1'b1;
    #1 check("t5_oe_async", 32'(bus.sig_oe), 32'd0);
    exp_q.delete();
    bus.en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      e.ch = i; e.t = NO_ECHO; e.valid = 1'b0; e.imm = 1'b1;
      exp_q.push_back(e);
    end
    drain("t5_bank_drain");
    bus.en = 1'b1;
    @(negedge clk);
    n = 0;
    while (bus.sig_oe == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_restart_ch0", 32'(bus.sig_oe), 32'b0001);
    bus.en = 1'b0;
    wait_idle("t5_idle", 500);
    drain("t5_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
